// File: rtl/sfu_pkg.sv
// Shared types and helpers for the special-function / psum accumulation stage.
// Includes the state encoding, the ReLU clamp and the column-reversal mapping.
package sfu_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } sfu_state_t;

    localparam int unsigned MAX_BW = 64;

    // Values are zero-extended into MAX_BW bits; bw selects the sign bit.
    function automatic logic [MAX_BW-1:0] relu(input logic [MAX_BW-1:0] v,
                                              input int unsigned        bw,
                                              input logic               en);
        relu = (en && v[6'(bw - 1)]) ? '0 : v;
    endfunction

    function automatic int unsigned col_src(input int unsigned i,
                                            input int unsigned n,
                                            input logic        rev);
        col_src = rev ? (n - 1 - i) : i;
    endfunction

endpackage

// File: rtl/sfu_col_buf.sv
// One column of psum storage: accumulate-in-place buffer in weight-stationary
// mode, FIFO in output-stationary mode. The read pointer is shared across columns.
module sfu_col_buf
    import sfu_pkg::*;
#(
    parameter  int unsigned psum_bw = 16,
    parameter  int unsigned depth   = 16,
    parameter  int unsigned nkernel = 9,
    localparam int unsigned AW      = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               restart,
    input  logic               mode,
    input  logic               wr_en,
    input  logic               pop,
    input  logic [AW-1:0]      rptr,
    input  logic [psum_bw-1:0] din,
    output logic [psum_bw-1:0] dout,
    output logic               done,
    output logic               full,
    output logic               done_next,
    output logic               full_next,
    output logic               empty_next
);

    localparam int unsigned   CW   = $clog2(depth + 1);
    localparam int unsigned   PW   = $clog2(nkernel + 1);
    localparam logic [AW-1:0] LAST = AW'(depth - 1);

    logic [psum_bw-1:0] mem [depth];
    logic [AW-1:0]      wptr, wptr_next;
    logic [PW-1:0]      pass, pass_next;
    logic [CW-1:0]      count, count_next;

    always_comb begin
        wptr_next  = wptr;
        pass_next  = pass;
        count_next = count;
        if (restart) begin
            wptr_next  = '0;
            pass_next  = '0;
            count_next = '0;
        end else begin
            if (wr_en) begin
                wptr_next = (wptr == LAST) ? '0 : wptr + 1'b1;
                if (!mode && (wptr == LAST)) begin
                    pass_next = pass + 1'b1;
                end
            end
            if (mode) begin
                if (wr_en && !pop) begin
                    count_next = count + 1'b1;
                end else if (!wr_en && pop) begin
                    count_next = count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            pass  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr_next;
            pass  <= pass_next;
            count <= count_next;
        end
    end

    // First pass overwrites stale contents, later passes add in place.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= (mode || (pass == '0)) ? din : mem[wptr] + din;
        end
    end

    assign dout       = mem[rptr];
    assign done       = (pass == PW'(nkernel));
    assign full       = (count == CW'(depth));
    assign done_next  = (pass_next == PW'(nkernel));
    assign full_next  = (count_next == CW'(depth));
    assign empty_next = (count_next == '0);

endmodule

// File: rtl/sfu_accum.sv
// Psum accumulation / FIFO stage between the MAC array and the psum bank.
// Holds the tile FSM, all-column reductions, output column mux and ReLU.
module sfu_accum
    import sfu_pkg::*;
#(
    parameter int unsigned psum_bw      = 16,
    parameter int unsigned col          = 8,
    parameter int unsigned depth        = 16,
    parameter int unsigned nkernel      = 9,
    parameter bit          reverse_cols = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   execution_mode,
    input  logic                   relu_en,
    input  logic                   acc_clear,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_ready_wr,
    output logic                   o_drain,
    output logic                   o_overflow
);

    localparam int unsigned   AW   = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [AW-1:0] LAST = AW'(depth - 1);

    sfu_state_t         state, state_next;
    logic               mode_q;
    logic [AW-1:0]      rptr, rptr_next;
    logic               clear, pop, drain_done, restart;
    logic               valid_next, ready_next, drain_next, overflow_next;
    logic [col-1:0]     accept, drop;
    logic [col-1:0]     done, full, done_next, full_next, empty_next;
    logic [psum_bw-1:0] col_data [col];

    // A mode change behaves exactly like an explicit clear on the same edge.
    assign clear = acc_clear | (execution_mode != mode_q);
    assign pop   = rd & o_valid & ~clear;

    genvar g;
    generate
        for (g = 0; g < col; g++) begin : g_col
            localparam int unsigned SRC = col_src(g, col, reverse_cols);

            assign accept[g] = wr[g] & ~clear &
                               (execution_mode ? ~full[g] : ((state == ACCUM) & ~done[g]));
            assign drop[g]   = wr[g] & ~clear & ~accept[g];

            sfu_col_buf #(
                .psum_bw (psum_bw),
                .depth   (depth),
                .nkernel (nkernel)
            ) u_col_buf (
                .clk        (clk),
                .reset      (reset),
                .restart    (restart),
                .mode       (execution_mode),
                .wr_en      (accept[g]),
                .pop        (pop),
                .rptr       (rptr),
                .din        (in[psum_bw*g +: psum_bw]),
                .dout       (col_data[g]),
                .done       (done[g]),
                .full       (full[g]),
                .done_next  (done_next[g]),
                .full_next  (full_next[g]),
                .empty_next (empty_next[g])
            );

            assign out[psum_bw*g +: psum_bw] =
                o_valid ? psum_bw'(relu(MAX_BW'(col_data[SRC]), psum_bw, relu_en)) : '0;
        end
    endgenerate

    always_comb begin
        drain_done = ~execution_mode & (state == DRAIN) & pop & (rptr == LAST);
        restart    = clear | drain_done;

        rptr_next = rptr;
        if (restart) begin
            rptr_next = '0;
        end else if (pop) begin
            rptr_next = (rptr == LAST) ? '0 : rptr + 1'b1;
        end

        state_next = state;
        if (clear) begin
            state_next = ACCUM;
        end else if (!execution_mode) begin
            case (state)
                ACCUM:   if (&done_next) state_next = DRAIN;
                DRAIN:   if (drain_done) state_next = ACCUM;
                default: state_next = ACCUM;
            endcase
        end

        valid_next    = execution_mode ? ~|empty_next : (state_next == DRAIN);
        ready_next    = execution_mode ? ~|full_next  : (state_next == ACCUM);
        drain_next    = ~execution_mode & (state_next == DRAIN);
        overflow_next = clear ? 1'b0 : (o_overflow | (|drop));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ACCUM;
            mode_q     <= 1'b0;
            rptr       <= '0;
            o_valid    <= 1'b0;
            o_ready_wr <= 1'b1;
            o_drain    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            state      <= state_next;
            mode_q     <= execution_mode;
            rptr       <= rptr_next;
            o_valid    <= valid_next;
            o_ready_wr <= ready_next;
            o_drain    <= drain_next;
            o_overflow <= overflow_next;
        end
    end

endmodule

// File: tb/tb_sfu_accum.sv
// Self-checking bench for sfu_accum: directed tile/FIFO sequences, a vector table
// and randomized traffic, all compared against a queue/array reference model.
module tb_sfu_accum;

    localparam int BW = 16;
    localparam int NC = 8;
    localparam int DP = 16;
    localparam int NK = 2;
    localparam bit REV = 1'b1;

    logic              clk = 1'b0;
    logic              reset;
    logic              execution_mode;
    logic              relu_en;
    logic              acc_clear;
    logic [BW*NC-1:0]  in_bus;
    logic [NC-1:0]     wr;
    logic              rd;
    logic [BW*NC-1:0]  out_bus;
    logic              o_valid, o_ready_wr, o_drain, o_overflow;

    int errors = 0;
    int checks = 0;

    sfu_accum #(
        .psum_bw      (BW),
        .col          (NC),
        .depth        (DP),
        .nkernel      (NK),
        .reverse_cols (REV)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .execution_mode (execution_mode),
        .relu_en        (relu_en),
        .acc_clear      (acc_clear),
        .in             (in_bus),
        .wr             (wr),
        .rd             (rd),
        .out            (out_bus),
        .o_valid        (o_valid),
        .o_ready_wr     (o_ready_wr),
        .o_drain        (o_drain),
        .o_overflow     (o_overflow)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [BW-1:0] acc [NC][DP];
    logic [BW-1:0] q [NC][$];
    int  pass_m [NC];
    int  wp_m [NC];
    int  rp_m;
    bit  drain_m, ovf_m, valid_m, ready_m, prev_mode;

    task automatic check(input string name, input logic [BW*NC-1:0] act, input logic [BW*NC-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BW*NC-1:0] fill(input logic [BW-1:0] v);
        return {NC{v}};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            pass_m[c] = 0;
            wp_m[c] = 0;
            q[c].delete();
        end
        rp_m = 0; drain_m = 0; ovf_m = 0; valid_m = 0; ready_m = 1;
    endtask

    task automatic model_update(input logic [NC-1:0] w, input logic [BW*NC-1:0] d,
                                input logic r, input logic clr);
        bit all_done, can_pop;
        if (clr || (execution_mode != prev_mode)) begin
            model_reset();
        end else if (!execution_mode) begin
            if (drain_m) begin
                if (w != 0) ovf_m = 1;
                if (r) begin
                    rp_m++;
                    if (rp_m == DP) begin
                        drain_m = 0; rp_m = 0;
                        for (int c = 0; c < NC; c++) begin pass_m[c] = 0; wp_m[c] = 0; end
                    end
                end
            end else begin
                for (int c = 0; c < NC; c++) begin
                    if (w[c]) begin
                        if (pass_m[c] == NK) ovf_m = 1;
                        else begin
                            acc[c][wp_m[c]] = (pass_m[c] == 0) ? d[BW*c +: BW]
                                                               : acc[c][wp_m[c]] + d[BW*c +: BW];
                            wp_m[c]++;
                            if (wp_m[c] == DP) begin wp_m[c] = 0; pass_m[c]++; end
                        end
                    end
                end
                all_done = 1;
                for (int c = 0; c < NC; c++) if (pass_m[c] != NK) all_done = 0;
                if (all_done) drain_m = 1;
            end
        end else begin
            can_pop = 1;
            for (int c = 0; c < NC; c++) if (q[c].size() == 0) can_pop = 0;
            for (int c = 0; c < NC; c++) begin
                bit was_full;
                was_full = (q[c].size() == DP);
                if (r && can_pop) void'(q[c].pop_front());
                if (w[c]) begin
                    if (was_full) ovf_m = 1;
                    else q[c].push_back(d[BW*c +: BW]);
                end
            end
        end
        prev_mode = execution_mode;
        if (execution_mode) begin
            valid_m = 1; ready_m = 1;
            for (int c = 0; c < NC; c++) begin
                if (q[c].size() == 0) valid_m = 0;
                if (q[c].size() == DP) ready_m = 0;
            end
        end else begin
            valid_m = drain_m;
            ready_m = !drain_m;
        end
    endtask

    function automatic logic [BW*NC-1:0] model_out();
        logic [BW*NC-1:0] r;
        logic [BW-1:0]    v;
        int               src;
        r = '0;
        if (valid_m) begin
            for (int i = 0; i < NC; i++) begin
                src = REV ? (NC - 1 - i) : i;
                v = execution_mode ? q[src][0] : acc[src][rp_m];
                if (relu_en && v[BW-1]) v = '0;
                r[BW*i +: BW] = v;
            end
        end
        return r;
    endfunction

    task automatic check_model(input string tag);
        check({tag, "/valid"},    o_valid,    valid_m);
        check({tag, "/ready"},    o_ready_wr, ready_m);
        check({tag, "/drain"},    o_drain,    drain_m && !execution_mode);
        check({tag, "/overflow"}, o_overflow, ovf_m);
        check({tag, "/out"},      out_bus,    model_out());
    endtask

    task automatic step(input logic [NC-1:0] w, input logic [BW*NC-1:0] d,
                        input logic r, input logic clr);
        wr = w; in_bus = d; rd = r; acc_clear = clr;
        @(posedge clk);
        model_update(w, d, r, clr);
        #1;
        check_model("step");
        wr = '0; rd = 1'b0; acc_clear = 1'b0;
    endtask

    task automatic drain_all(input string tag);
        for (int k = 0; k < DP; k++) step('0, '0, 1'b1, 1'b0);
        check({tag, " after drain"}, {o_valid, o_drain, o_ready_wr}, 3'b001);
    endtask

    typedef struct {
        logic [NC-1:0] wr;
        logic [BW-1:0] val;
        logic          rd;
        logic          relu;
        logic [2:0]    flags;   // {o_valid, o_ready_wr, o_overflow}
        logic [BW-1:0] o0;
        logic [BW-1:0] o7;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [BW*NC-1:0] bus;
        logic [BW-1:0]    lo, hi;

        tbl[0] = '{8'hFF, 16'd100,  1'b0, 1'b0, 3'b110, 16'd100, 16'd100};
        tbl[1] = '{8'hFF, 16'd200,  1'b0, 1'b0, 3'b110, 16'd100, 16'd100};
        tbl[2] = '{8'h00, 16'd0,    1'b1, 1'b0, 3'b110, 16'd200, 16'd200};
        tbl[3] = '{8'hFF, 16'hFFFB, 1'b1, 1'b1, 3'b110, 16'd0,   16'd0};
        tbl[4] = '{8'h00, 16'd0,    1'b1, 1'b0, 3'b010, 16'd0,   16'd0};
        tbl[5] = '{8'h00, 16'd0,    1'b1, 1'b0, 3'b010, 16'd0,   16'd0};
        tbl[6] = '{8'h01, 16'd7,    1'b0, 1'b0, 3'b010, 16'd0,   16'd0};
        tbl[7] = '{8'hFE, 16'd8,    1'b0, 1'b0, 3'b110, 16'd8,   16'd7};
        tbl[8] = '{8'h00, 16'd0,    1'b1, 1'b0, 3'b010, 16'd0,   16'd0};

        reset = 1'b0; execution_mode = 1'b0; relu_en = 1'b0; acc_clear = 1'b0;
        in_bus = '0; wr = '0; rd = 1'b0; prev_mode = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset out", out_bus, '0);
        check("reset flags", {o_valid, o_ready_wr, o_drain, o_overflow}, 4'b0100);
        #2 reset = 1'b1;
        @(posedge clk); #1;

        // Weight-stationary tile: 5 written twice at every entry.
        for (int p = 0; p < NK; p++)
            for (int e = 0; e < DP; e++) step('1, fill(16'd5), 1'b0, 1'b0);
        check("ws tile flags", {o_valid, o_drain, o_ready_wr}, 3'b110);
        for (int k = 0; k < DP; k++) begin
            check("ws pop value", out_bus, fill(16'd10));
            step('0, '0, 1'b1, 1'b0);
        end
        check("ws back to accum", {o_valid, o_drain, o_ready_wr}, 3'b001);

        // Negative sum through ReLU.
        for (int e = 0; e < DP; e++) step('1, fill(16'hFFFD), 1'b0, 1'b0);
        for (int e = 0; e < DP; e++) step('1, fill(16'h0000), 1'b0, 1'b0);
        relu_en = 1'b1; #1;
        check("relu clamps negative", out_bus, '0);
        relu_en = 1'b0; #1;
        check("relu off passes negative", out_bus, fill(16'hFFFD));
        drain_all("relu tile");

        // Column reversal.
        bus = '0;
        bus[BW-1:0] = 16'd1;
        bus[BW*(NC-1) +: BW] = 16'd7;
        for (int e = 0; e < DP; e++) step('1, bus, 1'b0, 1'b0);
        for (int e = 0; e < DP; e++) step('1, '0, 1'b0, 1'b0);
        lo = out_bus[BW-1:0];
        hi = out_bus[BW*(NC-1) +: BW];
        check("reverse out col0", lo, 16'd7);
        check("reverse out col7", hi, 16'd1);
        drain_all("reverse tile");

        // Output-stationary FIFO fill and overflow.
        execution_mode = 1'b1;
        step('0, '0, 1'b0, 1'b0);
        for (int k = 0; k < DP + 1; k++) begin
            step('1, fill(BW'(k + 1)), 1'b0, 1'b0);
            if (k == DP - 2) check("fifo ready before full", o_ready_wr, 1'b1);
            if (k == DP - 1) check("fifo full flags", {o_ready_wr, o_overflow}, 2'b00);
        end
        check("fifo overflow sticky", {o_ready_wr, o_overflow}, 2'b01);
        check("fifo first word", out_bus, fill(16'd1));
        step('0, '0, 1'b1, 1'b0);
        check("fifo second word", out_bus, fill(16'd2));
        step('0, '0, 1'b0, 1'b1);
        check("clear drops overflow", {o_valid, o_ready_wr, o_overflow}, 3'b010);

        // Vector table in output-stationary mode.
        for (int i = 0; i < 9; i++) begin
            relu_en = tbl[i].relu;
            step(tbl[i].wr, fill(tbl[i].val), tbl[i].rd, 1'b0);
            check("tbl flags", {o_valid, o_ready_wr, o_overflow}, tbl[i].flags);
            lo = out_bus[BW-1:0];
            hi = out_bus[BW*(NC-1) +: BW];
            check("tbl out col0", lo, tbl[i].o0);
            check("tbl out col7", hi, tbl[i].o7);
        end
        relu_en = 1'b0;

        // Skewed column arrival: column c starts c cycles late.
        execution_mode = 1'b0;
        step('0, '0, 1'b0, 1'b0);
        for (int t = 0; t < NK * DP + NC - 1; t++) begin
            logic [NC-1:0] m;
            for (int c = 0; c < NC; c++) m[c] = (t >= c) && (t < c + NK * DP);
            step(m, fill(16'd5), 1'b0, 1'b0);
            if (t < NK * DP + NC - 2) check("skew not yet valid", o_valid, 1'b0);
        end
        check("skew tile valid", {o_valid, o_drain}, 2'b11);
        check("skew value", out_bus, fill(16'd10));
        drain_all("skew tile");

        // Reset in the middle of a drain.
        for (int e = 0; e < NK * DP; e++) step('1, fill(16'd5), 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        check("mid-drain reset out", out_bus, '0);
        check("mid-drain reset flags", {o_valid, o_ready_wr, o_drain, o_overflow}, 4'b0100);
        model_reset();
        prev_mode = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        for (int e = 0; e < DP; e++) step('1, fill(16'd3), 1'b0, 1'b0);
        for (int e = 0; e < DP; e++) step('1, fill(16'd4), 1'b0, 1'b0);
        check("fresh tile from zero", out_bus, fill(16'd7));
        drain_all("fresh tile");

        // Randomized traffic in both modes.
        for (int n = 0; n < 2000; n++) begin
            logic [BW*NC-1:0] d;
            if ($urandom_range(0, 299) == 0) execution_mode = ~execution_mode;
            if ((n % 16) == 0) relu_en = 1'($urandom_range(0, 1));
            for (int c = 0; c < NC; c++) d[BW*c +: BW] = BW'($urandom);
            step(NC'($urandom), d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 255) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sfu_accum.md
# sfu_accum

Parametrised successor to the corelet's special-function/psum stage: sits between the MAC array's south psum outputs and the psum bank controller. Weight-stationary mode accumulates per-column psums across `nkernel` kernel passes of `depth` output pixels in place. Output-stationary mode acts as a per-column first-word-fall-through FIFO. Drained data gets optional ReLU and optional column-order reversal.

## Interface
- `psum_bw`, 16, psum width per column (signed two's complement)
- `col`, 8, number of columns (output channels)
- `depth`, 16, entries per column (output pixels per pass, len_onij)
- `nkernel`, 9, accumulation passes per tile in weight-stationary mode, ≥1
- `reverse_cols`, 1, 1 = output column i carries internal column col-1-i
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `execution_mode`  in  1  0 = weight-stationary accumulate, 1 = output-stationary FIFO
- `relu_en`  in  1  clamp negative outputs to 0
- `acc_clear`  in  1  synchronous clear of pointers, counters and state
- `in`  in  psum_bw*col  psums from MAC array, column c at [psum_bw*c +: psum_bw]
- `wr`  in  col  per-column write valid (columns arrive skewed)
- `rd`  in  1  pop one row (all columns)
- `out`  out  psum_bw*col  drained row; 0 when `o_valid`=0
- `o_valid`  out  1  a full row is readable
- `o_ready_wr`  out  1  no column is full / block is accepting writes
- `o_drain`  out  1  weight-stationary tile complete, draining
- `o_overflow`  out  1  sticky: a write was dropped

## Operation
- States: ACCUM, DRAIN. Reset → ACCUM.
- Weight-stationary, ACCUM: write to column c stores `in_c` at wptr[c] when pass[c]==0; otherwise stores entry+`in_c`, wrapping at psum_bw. wptr[c] increments; on wrap depth-1→0, pass[c] increments.
- When every pass[c]==nkernel: ACCUM → DRAIN. `o_valid`=1, `o_ready_wr`=0, `o_drain`=1.
- DRAIN: `rd` presents entry[rptr] for all columns; rptr increments. On the pop of entry depth-1, return to ACCUM and clear pass, wptr and rptr.
- Writes in DRAIN are dropped and set `o_overflow`.
- Output-stationary: each column is a depth-deep FIFO with count[c]. A write to a column with count==depth is dropped and sets `o_overflow`.
  - `o_valid` = all count[c]>0.
  - `rd` pops every column.
  - `o_ready_wr` = no count[c]==depth.
  - Simultaneous write+pop on the same column leaves count unchanged.
- `rd` while `o_valid`=0: ignored, no state change.
- ReLU applies to `out` only; stored sums stay unclamped.
- `acc_clear` takes priority over `wr`/`rd` in the same cycle. It clears `o_overflow` and returns to ACCUM.
- Toggling `execution_mode` mid-tile triggers an implicit `acc_clear` on the next edge.

## Timing
- Reset values: `out`=0, `o_valid`=0, `o_ready_wr`=1, `o_drain`=0, `o_overflow`=0. All counters 0, state ACCUM. Storage is not reset.
- Write at edge t is visible in `out` (FIFO mode) or in the accumulated value from edge t+1.
- `o_valid`, `o_drain` and `o_ready_wr` are registered. They update the cycle after the causing write or pop.
- `out` is combinational from storage at rptr (first-word-fall-through). It is valid in the same cycle as `o_valid`.
- Weight-stationary tile latency: the last column's final write at t gives `o_valid`=1 at t+1.
- Drain runs at one row per cycle with `rd` held high.

## Structure
- Package `sfu_pkg`: state enum {ACCUM, DRAIN}, `relu` function, and the column-reversal index function.
- Sub-module `sfu_col_buf`: one column's storage, wptr, rptr-shared read port, pass counter and FIFO count. Instantiated `col` times.
- Top level: FSM, all-column reductions, output mux and ReLU.

## Test plan
- Weight-stationary, depth=4, nkernel=2, all columns write 5 at every entry twice → `o_valid` next cycle. Four pops each give 10 on all columns, then ACCUM.
- Column c receives -3 (one pass, nkernel=1), `relu_en`=1 → `out` column 0. With `relu_en`=0 → 0xFFFD.
- `reverse_cols`=1, column 0 accumulates 1 and column 7 accumulates 7 → `out`[15:0]=7 and `out`[127:112]=1.
- Output-stationary, depth=16, 17 writes to every column with no pop → `o_ready_wr`=0 after the 16th. The 17th write sets `o_overflow`, and the first pop returns the first word.
- Skewed writes: column c starts c cycles later → tile completes one cycle after column 7's last write. Values match the unskewed run.
- `reset` asserted mid-DRAIN after 2 pops → all outputs at reset values immediately. A fresh tile after release accumulates from 0.
